console_usb_sched: RTL and testbench



---
 rtl/console_usb_sched.sv | 219 +++++++++++++++++++++
 tb/tb_console_usb_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_usb_sched.sv
// console_usb_sched
//   Shares one upstream "send to USB" request across eight USB channel
//   ports. Each accepted request services every channel selected in the
//   captured mask, one at a time, in round-robin order starting at a
//   persistent cursor. Each handshake phase (flag high waiting for done,
//   then waiting for done to drop) is bounded by TIMEOUT cycles; a channel
//   that overruns either phase is recorded in fail_mask.
//
// Ports
//   clk            : system clock
//   rst            : synchronous active-high reset
//   fs / fd        : upstream start (level) / upstream done
//   ch_mask        : channels to service, bit i = channel i (captured on accept)
//   btype          : packet type (captured on accept)
//   fs_usb_send    : per-channel start flags, at most one high
//   fd_usb_send    : per-channel done flags from the responders
//   send_usb_btype : per-channel type, bits [4i:4i+3] belong to channel i
//   fail_mask      : channels that timed out in the last request
//   busy           : high in every state except IDLE
module console_usb_sched #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [0:7]  ch_mask,
  input  logic [3:0]  btype,
  output logic [0:7]  fs_usb_send,
  input  logic [0:7]  fd_usb_send,
  output logic [0:31] send_usb_btype,
  output logic [0:7]  fail_mask,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [15:0] LP_CNT_LAST = TIMEOUT - 16'd1;

  state_t       r_state;
  logic [0:7]   r_pend;
  logic [2:0]   r_cur;
  logic [2:0]   r_cursor;
  logic [3:0]   r_btype;
  logic [15:0]  r_cnt;
  logic         r_fd;
  logic         r_busy;
  logic [0:7]   r_fs_send;
  logic [0:31]  r_send_btype;
  logic [0:7]   r_fail;

  state_t       w_state_nxt;
  logic [0:7]   w_pend_nxt;
  logic [2:0]   w_cur_nxt;
  logic [2:0]   w_cursor_nxt;
  logic [3:0]   w_btype_nxt;
  logic [15:0]  w_cnt_nxt;
  logic         w_fd_nxt;
  logic [0:7]   w_fs_send_nxt;
  logic [0:31]  w_send_btype_nxt;
  logic [0:7]   w_fail_nxt;

  logic [3:0]   w_pick;
  logic         w_fd_cur;
  logic         w_cnt_last;
  logic [2:0]   w_cur_inc;

  // Round-robin pick: {found, index} of the first set bit of pend at or
  // after start, wrapping 7->0. Walking the offsets downward lets the
  // smallest offset overwrite the result last.
  function automatic logic [3:0] f_pick(input logic [0:7] pend, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + i[2:0];
      if (pend[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_pick     = f_pick(r_pend, r_cursor);
  assign w_fd_cur   = fd_usb_send[r_cur];
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);
  assign w_cur_inc  = r_cur + 3'd1;

  // Next-state and next-register logic for the whole scheduler.
  always_comb begin
    w_state_nxt      = r_state;
    w_pend_nxt       = r_pend;
    w_cur_nxt        = r_cur;
    w_cursor_nxt     = r_cursor;
    w_btype_nxt      = r_btype;
    w_cnt_nxt        = r_cnt;
    w_fd_nxt         = r_fd;
    w_fs_send_nxt    = r_fs_send;
    w_send_btype_nxt = r_send_btype;
    w_fail_nxt       = r_fail;
    case (r_state)
      S_IDLE: begin
        if (fs && !r_fd) begin
          w_pend_nxt  = ch_mask;
          w_btype_nxt = btype;
          w_fail_nxt  = 8'h00;
          w_state_nxt = S_SCAN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (!w_pick[3]) begin
          w_fd_nxt    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cur_nxt = w_pick[2:0];
          w_cnt_nxt = 16'd0;
          // The flag and nibble are registered here so they appear in the
          // first SEND cycle.
          for (int j = 0; j < 8; j++) begin
            w_fs_send_nxt[j]            = (j[2:0] == w_pick[2:0]);
            w_send_btype_nxt[4*j +: 4]  = (j[2:0] == w_pick[2:0]) ? r_btype : 4'h0;
          end
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // Done wins over a timeout landing on the same cycle.
        if (w_fd_cur) begin
          w_pend_nxt[r_cur] = 1'b0;
          w_fs_send_nxt     = 8'h00;
          w_send_btype_nxt  = 32'h0;
          w_cnt_nxt         = 16'd0;
          w_state_nxt       = S_WAIT_LOW;
        end else if (w_cnt_last) begin
          w_fail_nxt[r_cur] = 1'b1;
          w_pend_nxt[r_cur] = 1'b0;
          w_fs_send_nxt     = 8'h00;
          w_send_btype_nxt  = 32'h0;
          w_cursor_nxt      = w_cur_inc;
          w_state_nxt       = S_SCAN;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WAIT_LOW: begin
        if (!w_fd_cur) begin
          w_cursor_nxt = w_cur_inc;
          w_state_nxt  = S_SCAN;
        end else if (w_cnt_last) begin
          w_fail_nxt[r_cur] = 1'b1;
          w_cursor_nxt      = w_cur_inc;
          w_state_nxt       = S_SCAN;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DONE: begin
        if (!fs) begin
          w_fd_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_fd_nxt         = 1'b0;
        w_fs_send_nxt    = 8'h00;
        w_send_btype_nxt = 32'h0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pend       <= 8'h00;
      r_cur        <= 3'd0;
      r_cursor     <= 3'd0;
      r_btype      <= 4'h0;
      r_cnt        <= 16'd0;
      r_fd         <= 1'b0;
      r_busy       <= 1'b0;
      r_fs_send    <= 8'h00;
      r_send_btype <= 32'h0;
      r_fail       <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_pend       <= w_pend_nxt;
      r_cur        <= w_cur_nxt;
      r_cursor     <= w_cursor_nxt;
      r_btype      <= w_btype_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fd         <= w_fd_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_fs_send    <= w_fs_send_nxt;
      r_send_btype <= w_send_btype_nxt;
      r_fail       <= w_fail_nxt;
    end
  end

  assign fd             = r_fd;
  assign busy           = r_busy;
  assign fs_usb_send    = r_fs_send;
  assign send_usb_btype = r_send_btype;
  assign fail_mask      = r_fail;

endmodule

// File: tb/tb_console_usb_sched.sv
module tb_console_usb_sched;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [0:7]  ch_mask;
  logic [3:0]  btype;
  logic [0:7]  fs_usb_send;
  logic [0:7]  fd_usb_send;
  logic [0:31] send_usb_btype;
  logic [0:7]  fail_mask;
  logic        busy;

  console_usb_sched #(.TIMEOUT(16'd8)) dut (
    .clk            (clk),
    .rst            (rst),
    .fs             (fs),
    .fd             (fd),
    .ch_mask        (ch_mask),
    .btype          (btype),
    .fs_usb_send    (fs_usb_send),
    .fd_usb_send    (fd_usb_send),
    .send_usb_btype (send_usb_btype),
    .fail_mask      (fail_mask),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Responder behaviour per channel: delay = cycles of flag-high before the
  // responder raises done (0 = never answers); stuck = keeps done high after
  // the flag drops; spur = done forced high regardless of anything.
  int         delay [8];
  bit         stuck [8];
  bit         stuck_on [8];
  logic [0:7] spur;

  // Monitor state
  int         hi_cnt [8];
  logic [0:7] prev_flag;
  int         order [$];
  int         first_flag;
  int         ncyc;
  logic [3:0] exp_btype;
  int         cursor_m;

  task automatic set_resp(input int d);
    for (int i = 0; i < 8; i++) begin
      delay[i]    = d;
      stuck[i]    = 1'b0;
      stuck_on[i] = 1'b0;
      hi_cnt[i]   = 0;
    end
    spur = 8'h00;
  endtask

  // One clock: observe outputs at the falling edge, then drive responders.
  task automatic cycle();
    int         ones;
    int         dur;
    logic [3:0] nib;
    logic [3:0] exp_nib;
    @(negedge clk);
    ncyc++;
    ones = $countones(fs_usb_send);
    n_vec++;
    if (ones > 1) begin
      n_bad++;
      $display("FAIL onehot: got %0d flags high, expected at most 1", ones);
    end
    for (int i = 0; i < 8; i++) begin
      nib     = send_usb_btype[4*i +: 4];
      exp_nib = fs_usb_send[i] ? exp_btype : 4'h0;
      n_vec++;
      if (nib !== exp_nib) begin
        n_bad++;
        $display("FAIL nibble ch%0d: got %h expected %h", i, nib, exp_nib);
      end
      if (fs_usb_send[i] && !prev_flag[i]) begin
        order.push_back(i);
        hi_cnt[i] = 0;
        if (first_flag < 0) first_flag = ncyc;
      end
      if (fs_usb_send[i]) hi_cnt[i]++;
      if (!fs_usb_send[i] && prev_flag[i]) begin
        dur = (delay[i] >= 1 && delay[i] <= TMO) ? delay[i] : TMO;
        n_vec++;
        if (hi_cnt[i] != dur) begin
          n_bad++;
          $display("FAIL flag_len ch%0d: got %0d cycles expected %0d", i, hi_cnt[i], dur);
        end
        if (stuck[i]) stuck_on[i] = 1'b1;
      end
    end
    prev_flag = fs_usb_send;
    for (int i = 0; i < 8; i++) begin
      fd_usb_send[i] = spur[i] | stuck_on[i] |
                       (fs_usb_send[i] && delay[i] > 0 && hi_cnt[i] >= delay[i]);
    end
  endtask

  // One upstream request, checked against an order/fail model derived from
  // the mask, the cursor and the responder behaviour.
  task automatic do_request(input logic [0:7] mask, input logic [3:0] bt, input int hold);
    int         exp_q [$];
    logic [0:7] exp_fail;
    int         done_cyc;
    int         ch;
    exp_fail = 8'h00;
    for (int k = 0; k < 8; k++) begin
      ch = (cursor_m + k) % 8;
      if (mask[ch]) begin
        exp_q.push_back(ch);
        if (delay[ch] == 0 || delay[ch] > TMO || stuck[ch]) exp_fail[ch] = 1'b1;
      end
    end
    if (exp_q.size() > 0) cursor_m = (exp_q[exp_q.size()-1] + 1) % 8;
    order      = {};
    first_flag = -1;
    ncyc       = 0;
    exp_btype  = bt;
    ch_mask    = mask;
    btype      = bt;
    fs         = 1'b1;
    done_cyc   = -1;
    for (int c = 0; c < 2000 && done_cyc < 0; c++) begin
      cycle();
      if (ncyc == 1) begin
        ch_mask = 8'($urandom);
        btype   = 4'($urandom);
      end
      if (fd === 1'b1) begin
        done_cyc = ncyc;
      end else begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_run: got %b expected 1 at cycle %0d", busy, ncyc);
        end
      end
    end
    n_vec++;
    if (done_cyc < 0) begin
      n_bad++;
      $display("FAIL done_timeout: fd not seen within 2000 cycles");
    end else begin
      n_vec++;
      if (order.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL order_len: got %0d channels expected %0d", order.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          n_vec++;
          if (order[k] != exp_q[k]) begin
            n_bad++;
            $display("FAIL order[%0d]: got ch%0d expected ch%0d", k, order[k], exp_q[k]);
          end
        end
      end
      n_vec++;
      if (fail_mask !== exp_fail) begin
        n_bad++;
        $display("FAIL fail_mask: got %b expected %b", fail_mask, exp_fail);
      end
      n_vec++;
      if (mask == 8'h00) begin
        if (done_cyc != 2) begin
          n_bad++;
          $display("FAIL empty_latency: fd at cycle %0d expected 2", done_cyc);
        end
      end else begin
        if (first_flag != 2) begin
          n_bad++;
          $display("FAIL start_latency: first flag at cycle %0d expected 2", first_flag);
        end
      end
      for (int h = 0; h < hold; h++) begin
        cycle();
        n_vec++;
        if (fd !== 1'b1 || fail_mask !== exp_fail) begin
          n_bad++;
          $display("FAIL done_hold: got fd=%b fail=%b expected fd=1 fail=%b", fd, fail_mask, exp_fail);
        end
      end
    end
    fs = 1'b0;
    cycle();
    n_vec++;
    if (fd !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL release: got fd=%b busy=%b expected 0 0", fd, busy);
    end
    for (int i = 0; i < 8; i++) stuck_on[i] = 1'b0;
    spur        = 8'h00;
    fd_usb_send = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; fs = 1'b0; ch_mask = 8'h00; btype = 4'h0; fd_usb_send = 8'h00;
    prev_flag = 8'h00; cursor_m = 0; exp_btype = 4'h0; first_flag = -1; ncyc = 0;
    set_resp(1);
    repeat (2) @(negedge clk);
    n_vec += 5;
    if (fd !== 1'b0)              begin n_bad++; $display("FAIL rst_fd: got %b expected 0", fd); end
    if (busy !== 1'b0)            begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (fs_usb_send !== 8'h00)    begin n_bad++; $display("FAIL rst_flags: got %b expected 0", fs_usb_send); end
    if (send_usb_btype !== 32'h0) begin n_bad++; $display("FAIL rst_btype: got %h expected 0", send_usb_btype); end
    if (fail_mask !== 8'h00)      begin n_bad++; $display("FAIL rst_fail: got %b expected 0", fail_mask); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_resp(1);
    do_request(8'b1010_0000, 4'h3, 3);
  endtask

  task automatic test_round_robin();
    set_resp(1);
    do_request(8'b1000_0000, 4'hA, 0);
    do_request(8'hFF, 4'h5, 1);
  endtask

  task automatic test_timeout();
    set_resp(0);
    do_request(8'b0100_0000, 4'hC, 0);
  endtask

  task automatic test_empty_collision();
    set_resp(1);
    do_request(8'h00, 4'h7, 2);
    set_resp(1);
    delay[3] = TMO;
    delay[4] = TMO + 1;
    do_request(8'b0001_1000, 4'h9, 0);
  endtask

  task automatic test_stuck_done();
    set_resp(1);
    stuck[3] = 1'b1;
    spur     = 8'b0000_0100;
    do_request(8'b0001_1000, 4'hE, 0);
  endtask

  task automatic test_reset_mid();
    int seen;
    set_resp(0);
    order = {}; first_flag = -1; ncyc = 0; exp_btype = 4'h6;
    ch_mask = 8'b0010_0100; btype = 4'h6; fs = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      cycle();
      if (fs_usb_send[2] === 1'b1) seen = 1;
    end
    n_vec++;
    if (seen == 0) begin
      n_bad++;
      $display("FAIL mid_flag2: flag 2 not seen within 200 cycles");
    end
    rst = 1'b1; fs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_vec += 4;
    if (fs_usb_send !== 8'h00)    begin n_bad++; $display("FAIL mid_flags: got %b expected 0", fs_usb_send); end
    if (send_usb_btype !== 32'h0) begin n_bad++; $display("FAIL mid_btype: got %h expected 0", send_usb_btype); end
    if (busy !== 1'b0 || fd !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got busy=%b fd=%b expected 0 0", busy, fd); end
    if (fail_mask !== 8'h00)      begin n_bad++; $display("FAIL mid_fail: got %b expected 0", fail_mask); end
    prev_flag   = 8'h00;
    fd_usb_send = 8'h00;
    cursor_m    = 0;
    set_resp(1);
    do_request(8'h01, 4'h2, 0);
    cursor_m = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_request(8'b1000_0001, 4'h4, 0);
  endtask

  task automatic test_random();
    logic [0:7] m;
    int         r;
    for (int it = 0; it < 25; it++) begin
      m = 8'($urandom);
      set_resp(1);
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      delay[i] = $urandom_range(1, 3);
        else if (r < 8) delay[i] = $urandom_range(TMO - 1, TMO + 1);
        else            delay[i] = 0;
        stuck[i] = ($urandom_range(0, 9) == 0);
        spur[i]  = !m[i] && ($urandom_range(0, 1) == 1);
      end
      do_request(m, 4'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_empty_collision();
    test_stuck_done();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
